// File: rtl/mac_seq.sv
// ---------------------------------------------------------------------------
// mac_seq : upstream sequencer for a multiply-accumulate (MAC) unit.
//   Pairs one A operand with one B operand per beat and drives the MAC's
//   Ain/Bin/En/Clr for a dot product of runtime length len. Once the MAC
//   pipeline has settled, it captures the accumulator and presents it on a
//   valid/ready result port. One dot product is in flight at a time.
//
// Ports
//   clk, rst          rising-edge clock, synchronous active-high reset
//   start, len        begin a dot product of len beats (sampled in IDLE only)
//   a_data/valid/ready  A operand stream
//   b_data/valid/ready  B operand stream (a_ready/b_ready are combinational)
//   mac_ain/bin/en/clr  registered drive to the MAC
//   mac_cout          MAC accumulator output (3*DATA_WIDTH)
//   res_data/valid/ready  captured dot product, held until accepted
//   busy              high whenever not IDLE
//
// Optional feature
//   MAC_SEQ_STALL_CNT_EN : adds output stall_cnt[15:0], a saturating count of
//   RUN cycles without a beat, cleared on an accepted start.
// ---------------------------------------------------------------------------
module mac_seq #(
   parameter int unsigned DATA_WIDTH = 8,
   parameter int unsigned LEN_W      = 8
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic                    start,
   input  logic [LEN_W-1:0]        len,
   input  logic [DATA_WIDTH-1:0]   a_data,
   input  logic                    a_valid,
   output logic                    a_ready,
   input  logic [DATA_WIDTH-1:0]   b_data,
   input  logic                    b_valid,
   output logic                    b_ready,
   output logic [DATA_WIDTH-1:0]   mac_ain,
   output logic [DATA_WIDTH-1:0]   mac_bin,
   output logic                    mac_en,
   output logic                    mac_clr,
   input  logic [3*DATA_WIDTH-1:0] mac_cout,
   output logic [3*DATA_WIDTH-1:0] res_data,
   output logic                    res_valid,
   input  logic                    res_ready,
   output logic                    busy
`ifdef MAC_SEQ_STALL_CNT_EN
   ,
   output logic [15:0]             stall_cnt
`endif
);

   localparam int unsigned ACC_W   = 3 * DATA_WIDTH;
   localparam int unsigned STALL_W = 16;

   typedef enum logic [2:0] {
      S_IDLE  = 3'd0,
      S_CLR   = 3'd1,
      S_RUN   = 3'd2,
      S_DRAIN = 3'd3,
      S_DONE  = 3'd4
   } state_t;

   state_t                r_state, w_state_nxt;
   logic [LEN_W-1:0]      r_cnt, w_cnt_nxt;
   logic [LEN_W-1:0]      r_len, w_len_nxt;
   logic                  r_dly, w_dly_nxt;
   logic [DATA_WIDTH-1:0] r_ain, w_ain_nxt;
   logic [DATA_WIDTH-1:0] r_bin, w_bin_nxt;
   logic                  r_en, w_en_nxt;
   logic                  r_clr, w_clr_nxt;
   logic [ACC_W-1:0]      r_res_data, w_res_data_nxt;
   logic                  r_res_valid, w_res_valid_nxt;
   logic                  r_busy, w_busy_nxt;

   logic                  w_run;
   logic                  w_fire;
   logic                  w_last;

   // Each stream's ready mirrors the other's valid, so neither is consumed alone.
   assign w_run   = (r_state == S_RUN);
   assign a_ready = w_run & b_valid;
   assign b_ready = w_run & a_valid;
   assign w_fire  = w_run & a_valid & b_valid;
   assign w_last  = (r_cnt == LEN_W'(r_len - LEN_W'(1)));

   // Next-state and next-output logic.
   always_comb begin
      w_state_nxt     = r_state;
      w_cnt_nxt       = r_cnt;
      w_len_nxt       = r_len;
      w_dly_nxt       = r_dly;
      w_ain_nxt       = r_ain;
      w_bin_nxt       = r_bin;
      w_en_nxt        = 1'b0;
      w_clr_nxt       = 1'b0;
      w_res_data_nxt  = r_res_data;
      w_res_valid_nxt = r_res_valid;

      case (r_state)
         S_IDLE: begin
            if (start) begin
               w_state_nxt = S_CLR;
               w_len_nxt   = len;
               w_cnt_nxt   = '0;
               w_clr_nxt   = 1'b1;
            end
         end
         S_CLR: begin
            w_dly_nxt   = 1'b0;
            w_state_nxt = (r_len == '0) ? S_DRAIN : S_RUN;
         end
         S_RUN: begin
            if (w_fire) begin
               w_ain_nxt = a_data;
               w_bin_nxt = b_data;
               w_en_nxt  = 1'b1;
               w_cnt_nxt = LEN_W'(r_cnt + LEN_W'(1));
               if (w_last) begin
                  w_state_nxt = S_DRAIN;
                  w_dly_nxt   = 1'b0;
               end
            end
         end
         S_DRAIN: begin
            // First cycle: last operands in the MAC input stage; second: Cout settled.
            w_dly_nxt = 1'b1;
            if (r_dly) begin
               w_res_data_nxt  = mac_cout;
               w_res_valid_nxt = 1'b1;
               w_state_nxt     = S_DONE;
            end
         end
         S_DONE: begin
            if (res_ready) begin
               w_res_valid_nxt = 1'b0;
               w_state_nxt     = S_IDLE;
            end
         end
         default: begin
            w_state_nxt = S_IDLE;
         end
      endcase

      w_busy_nxt = (w_state_nxt != S_IDLE);
   end

   // State and registered outputs.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_state     <= S_IDLE;
         r_cnt       <= '0;
         r_len       <= '0;
         r_dly       <= 1'b0;
         r_ain       <= '0;
         r_bin       <= '0;
         r_en        <= 1'b0;
         r_clr       <= 1'b0;
         r_res_data  <= '0;
         r_res_valid <= 1'b0;
         r_busy      <= 1'b0;
      end else begin
         r_state     <= w_state_nxt;
         r_cnt       <= w_cnt_nxt;
         r_len       <= w_len_nxt;
         r_dly       <= w_dly_nxt;
         r_ain       <= w_ain_nxt;
         r_bin       <= w_bin_nxt;
         r_en        <= w_en_nxt;
         r_clr       <= w_clr_nxt;
         r_res_data  <= w_res_data_nxt;
         r_res_valid <= w_res_valid_nxt;
         r_busy      <= w_busy_nxt;
      end
   end

   assign mac_ain   = r_ain;
   assign mac_bin   = r_bin;
   assign mac_en    = r_en;
   assign mac_clr   = r_clr;
   assign res_data  = r_res_data;
   assign res_valid = r_res_valid;
   assign busy      = r_busy;

`ifdef MAC_SEQ_STALL_CNT_EN
   logic [STALL_W-1:0] r_stall_cnt, w_stall_cnt_nxt;

   // Saturating count of RUN cycles without a beat.
   always_comb begin
      w_stall_cnt_nxt = r_stall_cnt;
      if ((r_state == S_IDLE) && start) begin
         w_stall_cnt_nxt = '0;
      end else if (w_run && !w_fire && (r_stall_cnt != {STALL_W{1'b1}})) begin
         w_stall_cnt_nxt = STALL_W'(r_stall_cnt + STALL_W'(1));
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_stall_cnt <= '0;
      end else begin
         r_stall_cnt <= w_stall_cnt_nxt;
      end
   end

   assign stall_cnt = r_stall_cnt;
`endif

endmodule

// File: tb/tb_mac_seq.sv
// ---------------------------------------------------------------------------
// tb_mac_seq : directed self-checking bench for mac_seq. A small behavioural
// MAC (clear / accumulate, registered Cout) closes the loop on the DUT.
// ---------------------------------------------------------------------------
module tb_mac_seq;

   localparam int unsigned DW = 8;
   localparam int unsigned LW = 8;
   localparam int unsigned AW = 3 * DW;

   logic          clk;
   logic          rst;
   logic          start;
   logic [LW-1:0] len;
   logic [DW-1:0] a_data;
   logic          a_valid;
   logic          a_ready;
   logic [DW-1:0] b_data;
   logic          b_valid;
   logic          b_ready;
   logic [DW-1:0] mac_ain;
   logic [DW-1:0] mac_bin;
   logic          mac_en;
   logic          mac_clr;
   logic [AW-1:0] mac_cout;
   logic [AW-1:0] res_data;
   logic          res_valid;
   logic          res_ready;
   logic          busy;
`ifdef MAC_SEQ_STALL_CNT_EN
   logic [15:0]   stall_cnt;
`endif

   int n_checks = 0;
   int n_fail   = 0;
   int en_cnt   = 0;
   int lone_cnt = 0;

   mac_seq #(.DATA_WIDTH(DW), .LEN_W(LW)) dut (
      .clk       (clk),
      .rst       (rst),
      .start     (start),
      .len       (len),
      .a_data    (a_data),
      .a_valid   (a_valid),
      .a_ready   (a_ready),
      .b_data    (b_data),
      .b_valid   (b_valid),
      .b_ready   (b_ready),
      .mac_ain   (mac_ain),
      .mac_bin   (mac_bin),
      .mac_en    (mac_en),
      .mac_clr   (mac_clr),
      .mac_cout  (mac_cout),
      .res_data  (res_data),
      .res_valid (res_valid),
      .res_ready (res_ready),
      .busy      (busy)
`ifdef MAC_SEQ_STALL_CNT_EN
      ,
      .stall_cnt (stall_cnt)
`endif
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Behavioural MAC: registered accumulator, clear has priority.
   always @(posedge clk) begin
      if (rst || mac_clr) mac_cout <= '0;
      else if (mac_en)    mac_cout <= mac_cout + AW'(mac_ain) * AW'(mac_bin);
   end

   // Activity monitors sampled at the active edge.
   always @(posedge clk) begin
      if (!rst) begin
         if (mac_en) en_cnt++;
         if ((a_valid && a_ready) != (b_valid && b_ready)) lone_cnt++;
      end
   end

   initial begin
      #3_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Pulse start from IDLE; returns in the CLR cycle.
   task automatic start_op(input logic [LW-1:0] l);
      start = 1'b1;
      len   = l;
      tick();
      start = 1'b0;
   endtask

   // Wait (bounded) until res_valid is high.
   task automatic wait_res(output bit ok);
      ok = 1'b0;
      for (int k = 0; k < 1000; k++) begin
         if (res_valid) begin
            ok = 1'b1;
            break;
         end
         tick();
      end
   endtask

   task automatic test_reset();
      rst = 1'b1;
      tick();
      tick();
      n_checks++;
      if ({busy, res_valid, mac_en, mac_clr, a_ready, b_ready} !== 6'b0) begin
         n_fail++;
         $display("FAIL rst_ctrl: got %b expected 000000",
                  {busy, res_valid, mac_en, mac_clr, a_ready, b_ready});
      end
      n_checks++;
      if ({res_data, mac_ain, mac_bin} !== '0) begin
         n_fail++;
         $display("FAIL rst_data: got res=%0d ain=%0d bin=%0d expected 0", res_data, mac_ain, mac_bin);
      end
`ifdef MAC_SEQ_STALL_CNT_EN
      n_checks++;
      if (stall_cnt !== 16'd0) begin
         n_fail++;
         $display("FAIL rst_stall: got %0d expected 0", stall_cnt);
      end
`endif
      rst = 1'b0;
      tick();
   endtask

   task automatic test_reset_mid_run();
      bit ok;
      start_op(8'd4);
      tick();
      a_valid = 1'b1; b_valid = 1'b1; a_data = 8'd7; b_data = 8'd9;
      tick();
      a_data = 8'd6; b_data = 8'd5;
      tick();
      rst = 1'b1;
      tick();
      n_checks++;
      if ({busy, res_valid, mac_en, mac_clr, a_ready, b_ready} !== 6'b0) begin
         n_fail++;
         $display("FAIL midrst_ctrl: got %b expected 000000",
                  {busy, res_valid, mac_en, mac_clr, a_ready, b_ready});
      end
      n_checks++;
      if ({res_data, mac_ain, mac_bin} !== '0) begin
         n_fail++;
         $display("FAIL midrst_data: got res=%0d ain=%0d bin=%0d expected 0", res_data, mac_ain, mac_bin);
      end
      tick();
      rst = 1'b0; a_valid = 1'b0; b_valid = 1'b0;
      tick();
      n_checks++;
      if (busy !== 1'b0) begin
         n_fail++;
         $display("FAIL midrst_idle: busy got %b expected 0", busy);
      end
      start_op(8'd1);
      tick();
      a_valid = 1'b1; b_valid = 1'b1; a_data = 8'd3; b_data = 8'd5;
      tick();
      a_valid = 1'b0; b_valid = 1'b0;
      wait_res(ok);
      n_checks++;
      if (!ok || res_data !== 24'd15) begin
         n_fail++;
         $display("FAIL midrst_fresh: got ok=%0d res=%0d expected res=15", ok, res_data);
      end
      tick();
   endtask

   task automatic test_back_to_back();
      logic [DW-1:0] av [3];
      logic [DW-1:0] bv [3];
      int en0;
      av[0] = 8'd1; av[1] = 8'd2; av[2] = 8'd3;
      bv[0] = 8'd4; bv[1] = 8'd5; bv[2] = 8'd6;
      en0 = en_cnt;
      start_op(8'd3);
      n_checks++;
      if (mac_clr !== 1'b1 || busy !== 1'b1) begin
         n_fail++;
         $display("FAIL b2b_clr_on: got clr=%b busy=%b expected 1 1", mac_clr, busy);
      end
      tick();
      n_checks++;
      if (mac_clr !== 1'b0) begin
         n_fail++;
         $display("FAIL b2b_clr_off: got %b expected 0", mac_clr);
      end
      for (int i = 0; i < 3; i++) begin
         a_data = av[i]; b_data = bv[i]; a_valid = 1'b1; b_valid = 1'b1;
         tick();
      end
      a_valid = 1'b0; b_valid = 1'b0;
      // cycle t+1 after last fire
      n_checks++;
      if (mac_en !== 1'b1 || mac_ain !== 8'd3 || mac_bin !== 8'd6 || res_valid !== 1'b0) begin
         n_fail++;
         $display("FAIL b2b_t1: got en=%b ain=%0d bin=%0d rv=%b expected 1 3 6 0",
                  mac_en, mac_ain, mac_bin, res_valid);
      end
      tick();
      n_checks++;
      if (res_valid !== 1'b0 || mac_en !== 1'b0) begin
         n_fail++;
         $display("FAIL b2b_t2: got rv=%b en=%b expected 0 0", res_valid, mac_en);
      end
      tick();
      n_checks++;
      if (res_valid !== 1'b1 || res_data !== 24'd32) begin
         n_fail++;
         $display("FAIL b2b_t3: got rv=%b res=%0d expected 1 32", res_valid, res_data);
      end
      n_checks++;
      if (en_cnt - en0 !== 3) begin
         n_fail++;
         $display("FAIL b2b_en_cycles: got %0d expected 3", en_cnt - en0);
      end
      tick();
      n_checks++;
      if (res_valid !== 1'b0 || busy !== 1'b0) begin
         n_fail++;
         $display("FAIL b2b_release: got rv=%b busy=%b expected 0 0", res_valid, busy);
      end
   endtask

   task automatic test_a_bubbles();
      bit ok;
      int lone0;
      lone0 = lone_cnt;
      start_op(8'd4);
      tick();
      for (int i = 0; i < 4; i++) begin
         a_data = 8'd2; b_data = 8'd2; a_valid = 1'b1; b_valid = 1'b1;
         #1;
         n_checks++;
         if (b_ready !== 1'b1 || a_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL bub_ready_on: beat %0d got a_rdy=%b b_rdy=%b expected 1 1", i, a_ready, b_ready);
         end
         tick();
         if (i < 3) begin
            a_valid = 1'b0; b_data = 8'd99;
            #1;
            n_checks++;
            if (b_ready !== 1'b0 || a_ready !== 1'b1) begin
               n_fail++;
               $display("FAIL bub_ready_off: beat %0d got a_rdy=%b b_rdy=%b expected 1 0", i, a_ready, b_ready);
            end
            tick();
         end
      end
      a_valid = 1'b0; b_valid = 1'b0;
      wait_res(ok);
      n_checks++;
      if (!ok || res_data !== 24'd16) begin
         n_fail++;
         $display("FAIL bub_res: got ok=%0d res=%0d expected 16", ok, res_data);
      end
      n_checks++;
      if (lone_cnt != lone0) begin
         n_fail++;
         $display("FAIL bub_lone: got %0d single-sided consumes expected 0", lone_cnt - lone0);
      end
      tick();
   endtask

   task automatic test_max_len();
      bit ok;
      int bad;
      res_ready = 1'b0;
      start_op(8'd255);
      tick();
      a_data = 8'd255; b_data = 8'd255; a_valid = 1'b1; b_valid = 1'b1;
      for (int i = 0; i < 255; i++) tick();
      a_valid = 1'b0; b_valid = 1'b0;
      wait_res(ok);
      n_checks++;
      if (!ok || res_data !== 24'd16581375) begin
         n_fail++;
         $display("FAIL max_res: got ok=%0d res=%0d expected 16581375", ok, res_data);
      end
      bad = 0;
      for (int i = 0; i < 10; i++) begin
         tick();
         if (res_valid !== 1'b1 || res_data !== 24'd16581375) bad++;
      end
      n_checks++;
      if (bad != 0) begin
         n_fail++;
         $display("FAIL max_hold: got %0d unstable cycles expected 0", bad);
      end
      res_ready = 1'b1;
      tick();
      n_checks++;
      if (res_valid !== 1'b0 || busy !== 1'b0) begin
         n_fail++;
         $display("FAIL max_release: got rv=%b busy=%b expected 0 0", res_valid, busy);
      end
   endtask

   task automatic test_len0_start_busy();
      int en0;
      en0 = en_cnt;
      res_ready = 1'b0;
      start_op(8'd0);
      n_checks++;
      if (mac_clr !== 1'b1) begin
         n_fail++;
         $display("FAIL len0_clr: got %b expected 1", mac_clr);
      end
      tick();
      start = 1'b1; len = 8'd5;
      tick();
      start = 1'b0;
      n_checks++;
      if (mac_clr !== 1'b0 || res_valid !== 1'b0) begin
         n_fail++;
         $display("FAIL len0_ignore_start: got clr=%b rv=%b expected 0 0", mac_clr, res_valid);
      end
      tick();
      n_checks++;
      if (res_valid !== 1'b1 || res_data !== 24'd0) begin
         n_fail++;
         $display("FAIL len0_res: got rv=%b res=%0d expected 1 0", res_valid, res_data);
      end
      start = 1'b1;
      tick();
      n_checks++;
      if (res_valid !== 1'b1 || busy !== 1'b1 || mac_clr !== 1'b0) begin
         n_fail++;
         $display("FAIL len0_done_start: got rv=%b busy=%b clr=%b expected 1 1 0", res_valid, busy, mac_clr);
      end
      res_ready = 1'b1;
      tick();
      start = 1'b0;
      n_checks++;
      if (res_valid !== 1'b0 || busy !== 1'b0 || mac_clr !== 1'b0) begin
         n_fail++;
         $display("FAIL len0_handshake_start: got rv=%b busy=%b clr=%b expected 0 0 0", res_valid, busy, mac_clr);
      end
      n_checks++;
      if (en_cnt != en0) begin
         n_fail++;
         $display("FAIL len0_no_en: got %0d en cycles expected 0", en_cnt - en0);
      end
      tick();
   endtask

`ifdef MAC_SEQ_STALL_CNT_EN
   task automatic test_stall_cnt();
      bit ok;
      start_op(8'd2);
      tick();
      a_valid = 1'b1; b_valid = 1'b0; a_data = 8'd1; b_data = 8'd2;
      tick(); tick(); tick();
      b_valid = 1'b1;
      tick();
      a_valid = 1'b0; b_valid = 1'b0; a_data = 8'd3; b_data = 8'd4;
      tick(); tick();
      a_valid = 1'b1; b_valid = 1'b1;
      tick();
      a_valid = 1'b0; b_valid = 1'b0;
      wait_res(ok);
      n_checks++;
      if (!ok || res_data !== 24'd14 || stall_cnt !== 16'd5) begin
         n_fail++;
         $display("FAIL stall_done: got ok=%0d res=%0d stall=%0d expected 14 5", ok, res_data, stall_cnt);
      end
      tick();
      n_checks++;
      if (stall_cnt !== 16'd5) begin
         n_fail++;
         $display("FAIL stall_hold: got %0d expected 5", stall_cnt);
      end
      start_op(8'd1);
      n_checks++;
      if (stall_cnt !== 16'd0) begin
         n_fail++;
         $display("FAIL stall_clear: got %0d expected 0", stall_cnt);
      end
      tick();
      a_valid = 1'b1; b_valid = 1'b1;
      tick();
      a_valid = 1'b0; b_valid = 1'b0;
      wait_res(ok);
      tick();
   endtask
`endif

   initial begin
      rst = 1'b1; start = 1'b0; len = '0;
      a_data = '0; a_valid = 1'b0; b_data = '0; b_valid = 1'b0;
      res_ready = 1'b1;
      test_reset();
      test_reset_mid_run();
      test_back_to_back();
      test_a_bubbles();
      test_max_len();
      test_len0_start_busy();
`ifdef MAC_SEQ_STALL_CNT_EN
      test_stall_cnt();
`endif
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
